// File: rtl/decode_stage.sv
// decode_stage: registered valid/ready instruction-decode stage with per-warp
// SYNC barrier and EXIT tracking.
//
// Instruction layout (DATA_WIDTH bits):
//   [DW-1:DW-3] opcode   000 R, 001 I, 010 M, 011 C, 100 P, 101 F, 11x undefined
//   [DW-4]      predicate bit (passed through as pred)
//   [13:10]     funct4   (funct3 = [12:10] for C-type)
// ALU op codes: ADD=0 MUL=1 SLLI=2 SUB=3 DIV=4 AND=5 OR=6 XOR=7 SEQ=8 SLT=9 SRL=10
// FALU op codes: FADD=0 FSUB=1 FMUL=2 FDIV=3 FMIN=4 FMAX=5
// C-type funct3: 000 jump, 001 branch, 010 call, 011 ret, 110 sync, 111 exit
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake; instr + in_warp
//   out_valid/out_ready      downstream handshake; out_warp, out_instr, control bundle
//   ALUctrl..pred, ImmSrc, Jump, illegal_instr   decoded control bundle
//   warp_stall               per-warp stall (waiting at barrier or exited)
//   sync_release             high during the cycle the barrier opens
//   all_done                 sticky once every warp has exited

// One warp's barrier bookkeeping: a wait bit cleared on release and a
// sticky exit bit. A set arriving in the release cycle wins over the clear.
module decode_warp_slot (
  input  logic clk,
  input  logic rst,
  input  logic set_wait,
  input  logic set_exit,
  input  logic clr_wait,
  output logic wait_q,
  output logic exit_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 1'b0;
      exit_q <= 1'b0;
    end else begin
      wait_q <= (wait_q & ~clr_wait) | set_wait;
      exit_q <= exit_q | set_exit;
    end
  end
endmodule

module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WARPS  = 4,
  parameter int WARP_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int FLOAT_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [WARP_W-1:0]     in_warp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WARP_W-1:0]     out_warp,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [3:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic                  branch,
  output logic                  RegWrite,
  output logic                  ResultSrc,
  output logic                  WD3Src,
  output logic                  WDME,
  output logic                  exit,
  output logic                  floating,
  output logic                  pred,
  output logic [2:0]            ImmSrc,
  output logic [1:0]            Jump,
  output logic                  illegal_instr,
  output logic [NUM_WARPS-1:0]  warp_stall,
  output logic                  sync_release,
  output logic                  all_done
);

  localparam logic [2:0] OP_R = 3'd0, OP_I = 3'd1, OP_M = 3'd2, OP_C = 3'd3,
                         OP_P = 3'd4, OP_F = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SEQ = 4'd8, ALU_LAST = 4'd10;
  localparam logic [3:0] FALU_ADD = 4'd0, FALU_LAST = 4'd5;

  typedef struct packed {
    logic [3:0] alu;
    logic       alusrc;
    logic       branch;
    logic       regwrite;
    logic       resultsrc;
    logic       wd3src;
    logic       wdme;
    logic       exit_f;
    logic       floating;
    logic       pred;
    logic [2:0] imm;
    logic [1:0] jump;
    logic       illegal;
  } ctrl_t;

  logic [2:0]           opc;
  logic [3:0]           f4;
  logic [2:0]           f3;
  logic                 warp_ok, stale, accept;
  logic                 is_sync, is_exit;
  ctrl_t                dec, bun;
  logic [NUM_WARPS-1:0] wait_mask, exit_mask, set_wait, set_exit;

  assign opc = instr[DATA_WIDTH-1 -: 3];
  assign f4  = instr[13:10];
  assign f3  = instr[12:10];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Warp IDs past NUM_WARPS only exist for non-power-of-two warp counts.
  assign warp_ok = 32'(in_warp) < NUM_WARPS;
  assign stale   = warp_ok && warp_stall[in_warp];

  always_comb begin
    dec      = '0;
    dec.alu  = ALU_ADD;
    dec.pred = instr[DATA_WIDTH-4];
    is_sync  = 1'b0;
    is_exit  = 1'b0;
    case (opc)
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.alu      = (f4 <= ALU_LAST) ? f4 : ALU_ADD;
      end
      OP_I: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = 3'd0;
        // ALU codes were chosen so the supported I-type funct4 values map 1:1.
        case (f4)
          4'b0000, 4'b0001, 4'b0010, 4'b0100: dec.alu = f4;
          default:                            dec.alu = ALU_ADD;
        endcase
      end
      OP_M: begin
        if (f4 == 4'b0000) begin
          dec.regwrite  = 1'b1;
          dec.alusrc    = 1'b1;
          dec.imm       = 3'd1;
          dec.resultsrc = 1'b1;
        end else if (f4 == 4'b0001) begin
          dec.wdme = 1'b1;
          dec.imm  = 3'd2;
        end
      end
      OP_C: begin
        case (f3)
          3'b000: begin
            dec.imm      = 3'd3;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.jump     = 2'b10;
            dec.wd3src   = 1'b1;
          end
          3'b001: begin
            dec.alu    = ALU_SEQ;
            dec.branch = 1'b1;
            dec.imm    = 3'd3;
          end
          3'b010: begin
            dec.imm      = 3'd4;
            dec.jump     = 2'b10;
            dec.wd3src   = 1'b1;
            dec.regwrite = 1'b1;
          end
          3'b011: begin
            dec.alusrc = 1'b1;
            dec.jump   = 2'b11;
          end
          3'b110: is_sync = 1'b1;
          3'b111: begin
            dec.exit_f = 1'b1;
            is_exit    = 1'b1;
          end
          default: ;
        endcase
      end
      OP_P: begin
        dec.imm      = 3'd5;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_F: begin
        if (FLOAT_EN != 0) begin
          dec.floating = 1'b1;
          dec.regwrite = 1'b1;
          dec.alu      = (f4 <= FALU_LAST) ? f4 : FALU_ADD;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Issue from a stalled or nonexistent warp: squash to an illegal bundle
    // and keep it away from the barrier masks.
    if (!warp_ok || stale) begin
      dec         = '0;
      dec.pred    = instr[DATA_WIDTH-4];
      dec.illegal = 1'b1;
      is_sync     = 1'b0;
      is_exit     = 1'b0;
    end
  end

  // Barrier opens when someone is waiting and every warp is waiting or gone.
  assign sync_release = (|wait_mask) && (&(wait_mask | exit_mask));
  assign warp_stall   = wait_mask | exit_mask;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign set_wait[w] = accept && is_sync && (in_warp == WARP_W'(w));
    assign set_exit[w] = accept && is_exit && (in_warp == WARP_W'(w));
    decode_warp_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .set_wait (set_wait[w]),
      .set_exit (set_exit[w]),
      .clr_wait (sync_release),
      .wait_q   (wait_mask[w]),
      .exit_q   (exit_mask[w])
    );
  end

  // Rises together with the final exit bit, then sticks until reset.
  always_ff @(posedge clk) begin
    if (rst)                           all_done <= 1'b0;
    else if (&(exit_mask | set_exit))  all_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_warp  <= '0;
      out_instr <= '0;
      bun       <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_warp  <= in_warp;
        out_instr <= instr;
        bun       <= dec;
      end
    end
  end

  assign ALUctrl       = bun.alu;
  assign ALUsrc        = bun.alusrc;
  assign branch        = bun.branch;
  assign RegWrite      = bun.regwrite;
  assign ResultSrc     = bun.resultsrc;
  assign WD3Src        = bun.wd3src;
  assign WDME          = bun.wdme;
  assign exit          = bun.exit_f;
  assign floating      = bun.floating;
  assign pred          = bun.pred;
  assign ImmSrc        = bun.imm;
  assign Jump          = bun.jump;
  assign illegal_instr = bun.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (FLOAT_EN=1 and FLOAT_EN=0) share one
// directed stimulus stream; a transaction-level model predicts both every cycle.
module tb_decode_stage;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [1:0]  in_warp = '0;

  logic [1:0]        o_in_ready, o_out_valid, o_alusrc, o_branch, o_regw, o_ress;
  logic [1:0]        o_wd3, o_wdme, o_exit, o_fl, o_pred, o_ill, o_rel, o_done;
  logic [1:0][1:0]   o_warp, o_jump;
  logic [1:0][31:0]  o_instr;
  logic [1:0][3:0]   o_alu, o_stall;
  logic [1:0][2:0]   o_imm;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage #(.DATA_WIDTH(32), .NUM_WARPS(NW), .WARP_W(2), .FLOAT_EN(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[g]),
      .instr(instr), .in_warp(in_warp), .out_valid(o_out_valid[g]), .out_ready(out_ready),
      .out_warp(o_warp[g]), .out_instr(o_instr[g]), .ALUctrl(o_alu[g]), .ALUsrc(o_alusrc[g]),
      .branch(o_branch[g]), .RegWrite(o_regw[g]), .ResultSrc(o_ress[g]), .WD3Src(o_wd3[g]),
      .WDME(o_wdme[g]), .exit(o_exit[g]), .floating(o_fl[g]), .pred(o_pred[g]),
      .ImmSrc(o_imm[g]), .Jump(o_jump[g]), .illegal_instr(o_ill[g]),
      .warp_stall(o_stall[g]), .sync_release(o_rel[g]), .all_done(o_done[g])
    );
  end

  typedef struct {
    bit [3:0] alu;
    bit alusrc, branch, regw, ress, wd3, wdme, ex, fl, pr;
    bit [2:0] imm;
    bit [1:0] jmp;
    bit ill;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit          m_valid;
  exp_t        m_bun [2];
  logic [31:0] m_instr;
  logic [1:0]  m_warp;
  bit [3:0]    m_wait, m_exit;
  bit          m_done;

  function automatic logic [31:0] mk(input bit [2:0] op, input bit p, input bit [3:0] f);
    logic [31:0] w;
    w = {op, p, 14'h1A5, 4'h0, 10'h23C};
    w[13:10] = f;
    return w;
  endfunction

  // What the spec says a word decodes to.
  function automatic exp_t model_dec(input logic [31:0] w, input bit fen, input bit stale,
                                     output bit sy, output bit ex);
    exp_t e;
    bit [2:0] op;
    bit [3:0] f;
    e = '{default: 0};
    op = w[31:29];
    f  = w[13:10];
    e.pr = w[28];
    sy = 0;
    ex = 0;
    if (stale || op >= 6 || (op == 5 && !fen)) begin
      e.ill = 1;
      return e;
    end
    if (op == 0) begin
      e.regw = 1;
      e.alu = (f <= 10) ? f : 4'd0;
    end else if (op == 1) begin
      e.regw = 1; e.alusrc = 1;
      e.alu = (f == 0 || f == 1 || f == 2 || f == 4) ? f : 4'd0;
    end else if (op == 2) begin
      if (f == 0) begin e.regw = 1; e.alusrc = 1; e.imm = 1; e.ress = 1; end
      if (f == 1) begin e.wdme = 1; e.imm = 2; end
    end else if (op == 3) begin
      if (f[2:0] == 0) begin e.imm = 3; e.alusrc = 1; e.regw = 1; e.jmp = 2; e.wd3 = 1; end
      if (f[2:0] == 1) begin e.alu = 8; e.branch = 1; e.imm = 3; end
      if (f[2:0] == 2) begin e.imm = 4; e.jmp = 2; e.wd3 = 1; e.regw = 1; end
      if (f[2:0] == 3) begin e.alusrc = 1; e.jmp = 3; end
      if (f[2:0] == 6) sy = 1;
      if (f[2:0] == 7) begin e.ex = 1; ex = 1; end
    end else if (op == 4) begin
      e.imm = 5; e.alusrc = 1; e.regw = 1;
    end else begin
      e.fl = 1; e.regw = 1;
      e.alu = (f <= 5) ? f : 4'd0;
    end
    return e;
  endfunction

  function automatic logic [18:0] pk(input exp_t e);
    return {e.alu, e.alusrc, e.branch, e.regw, e.ress, e.wd3, e.wdme, e.ex, e.fl, e.pr,
            e.imm, e.jmp, e.ill};
  endfunction

  function automatic logic [18:0] dut_pk(input int g);
    return {o_alu[g], o_alusrc[g], o_branch[g], o_regw[g], o_ress[g], o_wd3[g], o_wdme[g],
            o_exit[g], o_fl[g], o_pred[g], o_imm[g], o_jump[g], o_ill[g]};
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d]: got %0h, expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Model advances on each active edge using the inputs presented for that edge.
  always @(posedge clk) begin
    bit rel, rdy, acc, st, sy, ex, sy1, ex1;
    bit [3:0] sw, se;
    if (rst) begin
      m_valid = 0; m_wait = 0; m_exit = 0; m_done = 0;
      m_instr = '0; m_warp = '0;
      m_bun[0] = '{default: 0}; m_bun[1] = '{default: 0};
    end else begin
      rel = (m_wait != 0) && ((m_wait | m_exit) == 4'hF);
      rdy = !m_valid || out_ready;
      acc = in_valid && rdy;
      sw = 0; se = 0;
      if (acc) begin
        st = ((m_wait | m_exit) >> in_warp) & 1;
        m_bun[0] = model_dec(instr, 1, st, sy, ex);
        m_bun[1] = model_dec(instr, 0, st, sy1, ex1);
        if (sy) sw = 4'b1 << in_warp;
        if (ex) se = 4'b1 << in_warp;
        m_instr = instr;
        m_warp = in_warp;
      end
      m_wait = (rel ? 4'h0 : m_wait) | sw;
      m_exit = m_exit | se;
      if (m_exit == 4'hF) m_done = 1;
      if (rdy) m_valid = in_valid;
    end
  end

  // Single compare process, opposite edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      chk("in_ready", g, o_in_ready[g], !m_valid || out_ready);
      chk("out_valid", g, o_out_valid[g], m_valid);
      chk("warp_stall", g, o_stall[g], m_wait | m_exit);
      chk("sync_release", g, o_rel[g], (m_wait != 0) && ((m_wait | m_exit) == 4'hF));
      chk("all_done", g, o_done[g], m_done);
      if (m_valid)
        chk("bundle", g, {o_warp[g], o_instr[g], dut_pk(g)}, {m_warp, m_instr, pk(m_bun[g])});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic issue(input logic [31:0] w, input logic [1:0] wp);
    in_valid = 1; instr = w; in_warp = wp;
    tick(1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    tick(n);
  endtask

  localparam bit [2:0] R = 0, I = 1, M = 2, C = 3, P = 4, F = 5;

  initial begin
    logic [31:0] x1;
    rst = 1; out_ready = 1;
    tick(2);
    rst = 0;
    // reset state
    chk("rst_out_valid", 0, o_out_valid[0], 0);
    chk("rst_stall", 0, o_stall[0], 0);
    chk("rst_done", 0, o_done[0], 0);
    chk("rst_bundle", 0, {o_instr[0], dut_pk(0)}, 0);

    // back-to-back MUL
    issue(mk(I, 0, 4'b0001), 2'd0);
    chk("mul_valid", 0, o_out_valid[0], 1);
    chk("mul_ctl", 0, {o_alu[0], o_alusrc[0], o_regw[0]}, {4'd1, 1'b1, 1'b1});
    issue(mk(I, 1, 4'b0001) ^ 32'h0000_0003, 2'd1);
    issue(mk(I, 0, 4'b0001) ^ 32'h0000_0030, 2'd2);
    issue(mk(I, 0, 4'b0001) ^ 32'h0000_0300, 2'd3);
    idle(1);
    chk("drain_valid", 0, o_out_valid[0], 0);

    // backpressure
    x1 = mk(R, 0, 4'd3);
    out_ready = 0;
    issue(x1, 2'd1);
    instr = mk(R, 1, 4'd5); in_warp = 2'd2;
    tick(3);
    chk("bp_in_ready", 0, o_in_ready[0], 0);
    chk("bp_hold", 0, {o_instr[0], o_alu[0]}, {x1, 4'd3});
    out_ready = 1;
    tick(1);
    issue(mk(R, 0, 4'd7), 2'd3);
    idle(2);

    // decode sweep
    issue(mk(R, 0, 4'd13), 2'd0);
    issue(mk(I, 0, 4'd4), 2'd0);
    issue(mk(I, 1, 4'd2), 2'd0);
    issue(mk(I, 0, 4'd7), 2'd0);
    issue(mk(M, 0, 4'd0), 2'd1);
    chk("load", 0, {o_regw[0], o_alusrc[0], o_imm[0], o_ress[0]}, {1'b1, 1'b1, 3'd1, 1'b1});
    issue(mk(M, 1, 4'd1), 2'd1);
    issue(mk(M, 0, 4'd6), 2'd1);
    issue(mk(C, 0, 4'd0), 2'd2);
    chk("jump", 0, {o_imm[0], o_jump[0], o_wd3[0]}, {3'd3, 2'b10, 1'b1});
    issue(mk(C, 1, 4'd1), 2'd2);
    chk("branch", 0, {o_alu[0], o_branch[0], o_pred[0]}, {4'd8, 1'b1, 1'b1});
    issue(mk(C, 0, 4'd2), 2'd2);
    issue(mk(C, 0, 4'd3), 2'd2);
    issue(mk(C, 0, 4'd4), 2'd2);
    issue(mk(P, 0, 4'd9), 2'd3);
    issue(mk(F, 0, 4'd2), 2'd3);
    chk("fmul_en", 0, {o_fl[0], o_alu[0], o_ill[0]}, {1'b1, 4'd2, 1'b0});
    chk("fmul_dis", 1, {o_ill[1], o_fl[1], o_regw[1]}, {1'b1, 1'b0, 1'b0});
    issue(mk(F, 1, 4'd9), 2'd3);
    issue(mk(3'd6, 0, 4'd0), 2'd0);
    issue(mk(3'd7, 1, 4'd1), 2'd0);
    idle(1);

    // barrier: SYNC 0,1,2 then EXIT 3
    issue(mk(C, 0, 4'd6), 2'd0);
    chk("stall_0001", 0, o_stall[0], 4'b0001);
    issue(mk(C, 0, 4'd6), 2'd1);
    issue(mk(C, 0, 4'd6), 2'd2);
    chk("stall_0111", 0, o_stall[0], 4'b0111);
    issue(mk(C, 0, 4'd7), 2'd3);
    chk("stall_1111", 0, {o_stall[0], o_rel[0]}, {4'b1111, 1'b1});
    idle(1);
    chk("stall_1000", 0, {o_stall[0], o_rel[0]}, {4'b1000, 1'b0});
    issue(mk(R, 0, 4'd1), 2'd3);
    chk("stale_w3", 0, {o_ill[0], o_regw[0]}, {1'b1, 1'b0});
    issue(mk(R, 0, 4'd1), 2'd0);

    // all warps exit
    issue(mk(C, 0, 4'd7), 2'd0);
    issue(mk(C, 0, 4'd7), 2'd1);
    issue(mk(C, 0, 4'd7), 2'd2);
    chk("all_done_rise", 0, o_done[0], 1);
    idle(3);
    chk("all_done_hold", 0, o_done[0], 1);
    issue(mk(I, 0, 4'd0), 2'd2);
    chk("after_done_ill", 0, o_ill[0], 1);
    idle(1);

    // reset while busy with wait_mask=0011
    rst = 1; tick(1); rst = 0;
    issue(mk(C, 0, 4'd6), 2'd0);
    issue(mk(C, 0, 4'd6), 2'd1);
    out_ready = 0;
    idle(1);
    chk("pre_rst", 0, {o_out_valid[0], o_stall[0]}, {1'b1, 4'b0011});
    rst = 1; tick(1); rst = 0;
    chk("mid_rst", 0, {o_out_valid[0], o_stall[0], o_done[0], dut_pk(0)}, 0);
    out_ready = 1;
    issue(mk(R, 0, 4'd6), 2'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
